imem_prog_loader: RTL and testbench

- Front-end loader that sits directly upstream of the pipeline's fetch-stage instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes those words sequentially into imem from word address 0.
- Holds the pipeline core in reset until the program is fully loaded, replacing file-based preload for hardware bring-up.

---
 rtl/imem_prog_loader.sv | 151 +++++++++++++++
 tb/tb_imem_prog_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog_loader.sv
// imem_prog_loader
//   Byte-stream program loader feeding the fetch-stage instruction memory.
//   Bytes arriving over a valid/ready handshake are packed little-endian into
//   32-bit words and written to imem from word address 0 upward. The core is
//   held in reset until the final byte (s_last) has been written.
//
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//     defined   -> checksum is the mod-2^32 sum of every word written this load
//     undefined -> checksum is constant zero, no adder
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   s_valid/s_ready byte-stream handshake; s_data byte, s_last final byte
//   load_req        pulse; restarts loading from DONE or ERR
//   imem_we/_waddr/_wdata  imem write port (one word per strobe)
//   core_rst_n      active-low reset to the pipeline core
//   load_done       program loaded successfully
//   overflow_err    program exceeded IMEM_DEPTH words
//   word_count      words written in the current load
//   checksum        additive checksum of written words (see macro above)
module imem_prog_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(IMEM_DEPTH);

  typedef enum logic [1:0] {LOAD, DONE, ERR} state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;   // lanes 0..2 of the word being assembled
  logic        accept;
  logic        restart;
  logic [31:0] assembled;

  assign accept  = s_valid && s_ready;
  assign restart = load_req && (state != LOAD);

  // Lanes above the current byte are zero so a short final word is padded
  // without ever clearing word_buf.
  always_comb begin
    assembled = '0;
    case (byte_idx)
      2'd0: assembled = {24'h0, s_data};
      2'd1: assembled = {16'h0, s_data, word_buf[7:0]};
      2'd2: assembled = {8'h0, s_data, word_buf[15:0]};
      default: assembled = {s_data, word_buf[23:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      byte_idx     <= '0;
      word_buf     <= '0;
      word_count   <= '0;
      s_ready      <= 1'b0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      core_rst_n   <= 1'b0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (byte_idx == 2'd3 || s_last) begin
              byte_idx <= '0;
              // Overflow wins over s_last: the word is dropped and we drain.
              if (word_count == DEPTH_CNT) begin
                overflow_err <= 1'b1;
                state        <= ERR;
              end else begin
                imem_we    <= 1'b1;
                imem_waddr <= word_count[ADDR_W-1:0];
                imem_wdata <= assembled;
                word_count <= word_count + (ADDR_W+1)'(1);
                if (s_last) begin
                  state   <= DONE;
                  s_ready <= 1'b0;
                end
              end
            end else begin
              case (byte_idx)
                2'd0:    word_buf[7:0]   <= s_data;
                2'd1:    word_buf[15:8]  <= s_data;
                default: word_buf[23:16] <= s_data;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        DONE, ERR: begin
          if (restart) begin
            state        <= LOAD;
            s_ready      <= 1'b1;
            byte_idx     <= '0;
            word_count   <= '0;
            core_rst_n   <= 1'b0;
            load_done    <= 1'b0;
            overflow_err <= 1'b0;
          end else if (state == DONE) begin
            s_ready    <= 1'b0;
            load_done  <= 1'b1;
            core_rst_n <= 1'b1;
          end else begin
            s_ready <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Accumulates on the edge that samples imem_we, so the last word is
  // included by the time load_done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (restart) begin
      checksum <= '0;
    end else if (imem_we) begin
      checksum <= checksum + imem_wdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_prog_loader.sv
module tb_imem_prog_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = '0;
  logic          s_last = 1'b0;
  logic          load_req = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          overflow_err;
  logic [AW:0]   word_count;
  logic [31:0]   checksum;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t exp_q[$];

  imem_prog_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .load_req(load_req),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done),
    .overflow_err(overflow_err), .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every imem write is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected",
                 imem_waddr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_waddr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL imem_write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                   imem_waddr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted,
  // leaving s_valid high so back-to-back calls give full throughput.
  task automatic send(input logic [7:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready 0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("reload_core_rst_n", 32'(core_rst_n), 0);
    chk("reload_word_count", 32'(word_count), 0);
    chk("reload_load_done",  32'(load_done), 0);
    chk("reload_overflow",   32'(overflow_err), 0);
    chk("reload_checksum",   checksum, 0);
  endtask

  initial begin
    logic [7:0] b1 [8];
    logic [31:0] exp_sum;
    b1 = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};

    repeat (2) @(negedge clk);
    chk("rst_s_ready",    32'(s_ready), 0);
    chk("rst_imem_we",    32'(imem_we), 0);
    chk("rst_waddr",      32'(imem_waddr), 0);
    chk("rst_wdata",      imem_wdata, 0);
    chk("rst_core_rst_n", 32'(core_rst_n), 0);
    chk("rst_load_done",  32'(load_done), 0);
    chk("rst_word_count", 32'(word_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(s_ready), 1);

    // Two full words, back-to-back bytes (byte 4 accepted during imem_we).
    expect_wr(0, 32'h00500013);
    expect_wr(1, 32'h00A00093);
    for (int i = 0; i < 8; i++) send(b1[i], i == 7);
    chk("t1_done_not_yet", 32'(load_done), 0);
    idle();
    chk("t1_load_done",  32'(load_done), 1);
    chk("t1_core_rst_n", 32'(core_rst_n), 1);
    chk("t1_word_count", 32'(word_count), 2);
    chk("t1_s_ready",    32'(s_ready), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_sum = 32'h00F000A6;
`else
    exp_sum = 32'h0;
`endif
    chk("t1_checksum", checksum, exp_sum);

    // Partial last word: upper lane zero-padded.
    pulse_load_req();
    chk("t2_s_ready", 32'(s_ready), 1);
    expect_wr(0, 32'h00CCBBAA);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    idle();
    chk("t2_load_done",  32'(load_done), 1);
    chk("t2_word_count", 32'(word_count), 1);

    // Valid toggling every other cycle.
    pulse_load_req();
    expect_wr(0, 32'h44332211);
    expect_wr(1, 32'h88776655);
    for (int i = 0; i < 8; i++) begin
      send(8'((i + 1) * 8'h11), i == 7);
      idle();
    end
    chk("t4_load_done",  32'(load_done), 1);
    chk("t4_word_count", 32'(word_count), 2);

    // Overflow: 20 bytes into a 4-word imem.
    pulse_load_req();
    for (int w = 0; w < 4; w++)
      expect_wr(AW'(w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    for (int i = 0; i < 20; i++) begin
      send(8'(i), i == 19);
      if (i < 19) chk("t3_s_ready_hold", 32'(s_ready), 1);
    end
    idle();
    chk("t3_overflow",   32'(overflow_err), 1);
    chk("t3_core_rst_n", 32'(core_rst_n), 0);
    chk("t3_load_done",  32'(load_done), 0);
    chk("t3_word_count", 32'(word_count), 4);
    chk("t3_s_ready",    32'(s_ready), 1);
    send(8'h55, 1'b0);   // drained
    idle();
    chk("t3_overflow_hold", 32'(overflow_err), 1);

    // Reload from ERR, checksum words 1 and FFFFFFFF wrap to zero.
    pulse_load_req();
    expect_wr(0, 32'h00000001);
    expect_wr(1, 32'hFFFFFFFF);
    send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b1);
    idle();
    chk("t6_load_done", 32'(load_done), 1);
    chk("t6_checksum",  checksum, 0);

    // Reset mid-load after two bytes: nothing written, reset values.
    pulse_load_req();
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_imem_we",    32'(imem_we), 0);
    chk("mid_rst_word_count", 32'(word_count), 0);
    chk("mid_rst_s_ready",    32'(s_ready), 0);
    chk("mid_rst_core_rst_n", 32'(core_rst_n), 0);
    chk("mid_rst_load_done",  32'(load_done), 0);
    chk("mid_rst_wdata",      imem_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_after_we", 32'(imem_we), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
